uart_loop_fifo: RTL and testbench

//  UART echo block: a parametrised RX deserialiser, an elastic FIFO and a TX serialiser in one module.

---
 rtl/uart_loop_fifo.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_loop_fifo.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: UART echo path, RX deserialiser -> FIFO -> TX serialiser.
// Configurable data/parity/stop framing, TX flow control and error pulses.
module uart_loop_fifo #(
    parameter int BAUD_SET_COUNTER = 10416,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          tx_pause,
    output logic                          txd,
    output logic                          rx_busy,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          par_err,
    output logic                          frm_err,
    output logic                          ovf_err
);
    localparam int CW = $clog2(BAUD_SET_COUNTER);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] TERM = CW'(BAUD_SET_COUNTER - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_SET_COUNTER / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PAR, R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE, T_LOAD, T_START, T_DATA, T_PAR, T_STOP
    } tx_state_t;

    // Parity bit that accompanies a data word (odd or even).
    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : ^d;
    endfunction

    logic rxd_meta, rxd_sync, rxd_prev, rx_fall;

    rx_state_t rx_st, rx_st_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [BW-1:0] rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic rx_par, rx_par_n;
    logic rx_valid, par_err_n, frm_err_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, push, pop;

    tx_state_t tx_st, tx_st_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [BW-1:0] tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic tx_par, tx_par_n;
    logic tx_stop, tx_stop_n;
    logic txd_n;

    // Two-stage synchroniser plus one history stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rxd_meta, rxd_sync, rxd_prev} <= 3'b111;
        end else begin
            {rxd_meta, rxd_sync, rxd_prev} <= {rxd, rxd_meta, rxd_sync};
        end
    end

    assign rx_fall = rxd_prev & ~rxd_sync;
    assign rx_busy = (rx_st != R_IDLE);
    assign tx_busy = (tx_st != T_IDLE);

    // RX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st   <= R_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            rx_par  <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_bit  <= rx_bit_n;
            rx_sh   <= rx_sh_n;
            rx_par  <= rx_par_n;
            par_err <= par_err_n;
            frm_err <= frm_err_n;
        end
    end

    // RX next state: centre-sampled bits, word checked at the stop bit.
    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_cnt + CW'(1);
        rx_bit_n  = rx_bit;
        rx_sh_n   = rx_sh;
        rx_par_n  = rx_par;
        rx_valid  = 1'b0;
        par_err_n = 1'b0;
        frm_err_n = 1'b0;
        unique case (rx_st)
            R_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) begin
                    rx_st_n  = R_START;
                    rx_bit_n = '0;
                end
            end
            R_START: begin
                if (rx_cnt == HALF) begin
                    rx_cnt_n = '0;
                    rx_st_n  = rxd_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt == TERM) begin
                    rx_cnt_n = '0;
                    rx_sh_n  = {rxd_sync, rx_sh[DATA_BITS-1:1]};
                    rx_bit_n = rx_bit + BW'(1);
                    if (rx_bit == LAST) begin
                        rx_st_n = (PARITY != 0) ? R_PAR : R_STOP;
                    end
                end
            end
            R_PAR: begin
                if (rx_cnt == TERM) begin
                    rx_cnt_n = '0;
                    rx_par_n = rxd_sync;
                    rx_st_n  = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt == TERM) begin
                    rx_cnt_n = '0;
                    rx_st_n  = R_IDLE;
                    if (!rxd_sync) begin
                        frm_err_n = 1'b1;
                    end else if (PARITY != 0 && rx_par != par_of(rx_sh)) begin
                        par_err_n = 1'b1;
                    end else begin
                        rx_valid = 1'b1;
                    end
                end
            end
            default: rx_st_n = R_IDLE;
        endcase
    end

    assign full = (fifo_cnt == FULL);
    assign push = rx_valid && (!full || pop);

    // FIFO storage; a pop in the same cycle frees the slot being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_sh;
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + NW'(push) - NW'(pop);
            ovf_err  <= rx_valid && full && !pop;
        end
    end

    // TX state and datapath registers; txd idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st   <= T_IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_sh   <= '0;
            tx_par  <= 1'b0;
            tx_stop <= 1'b0;
            txd     <= 1'b1;
        end else begin
            tx_st   <= tx_st_n;
            tx_cnt  <= tx_cnt_n;
            tx_bit  <= tx_bit_n;
            tx_sh   <= tx_sh_n;
            tx_par  <= tx_par_n;
            tx_stop <= tx_stop_n;
            txd     <= txd_n;
        end
    end

    // TX next state: pop in IDLE, each bit held one full baud period.
    always_comb begin
        tx_st_n   = tx_st;
        tx_cnt_n  = tx_cnt + CW'(1);
        tx_bit_n  = tx_bit;
        tx_sh_n   = tx_sh;
        tx_par_n  = tx_par;
        tx_stop_n = tx_stop;
        txd_n     = txd;
        pop       = 1'b0;
        unique case (tx_st)
            T_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (fifo_cnt != '0 && !tx_pause) begin
                    pop     = 1'b1;
                    tx_sh_n = mem[rd_ptr];
                    tx_st_n = T_LOAD;
                end
            end
            T_LOAD: begin
                tx_cnt_n  = '0;
                tx_bit_n  = '0;
                tx_stop_n = 1'b0;
                tx_par_n  = par_of(tx_sh);
                txd_n     = 1'b0;
                tx_st_n   = T_START;
            end
            T_START: begin
                if (tx_cnt == TERM) begin
                    tx_cnt_n = '0;
                    txd_n    = tx_sh[0];
                    tx_st_n  = T_DATA;
                end
            end
            T_DATA: begin
                if (tx_cnt == TERM) begin
                    tx_cnt_n = '0;
                    if (tx_bit == LAST) begin
                        if (PARITY != 0) begin
                            txd_n   = tx_par;
                            tx_st_n = T_PAR;
                        end else begin
                            txd_n   = 1'b1;
                            tx_st_n = T_STOP;
                        end
                    end else begin
                        tx_bit_n = tx_bit + BW'(1);
                        tx_sh_n  = tx_sh >> 1;
                        txd_n    = tx_sh[1];
                    end
                end
            end
            T_PAR: begin
                if (tx_cnt == TERM) begin
                    tx_cnt_n = '0;
                    txd_n    = 1'b1;
                    tx_st_n  = T_STOP;
                end
            end
            T_STOP: begin
                if (tx_cnt == TERM) begin
                    tx_cnt_n = '0;
                    if (tx_stop == STOP_LAST) begin
                        tx_st_n = T_IDLE;
                    end else begin
                        tx_stop_n = 1'b1;
                    end
                end
            end
            default: tx_st_n = T_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: drives framed bytes into two configurations (8N1, 7E2)
// and decodes txd back into frames, compared against expected byte queues.
module tb_uart_loop_fifo;
    localparam int B     = 16;
    localparam int LEN0  = B * 10 + 2;
    localparam int BUSY1 = 1 + B * 11;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop_ok;
        int         t0;
    } frm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd0 = 1'b1, rxd1 = 1'b1, pause0 = 1'b0, pause1 = 1'b0;
    logic txd0, txd1, rxb0, rxb1, txb0, txb1;
    logic pe0, pe1, fe0, fe1, oe0, oe1;
    logic [2:0] cnt0, cnt1;

    int n_chk = 0, n_fail = 0, cyc = 0, last_ts = 0;
    int npar0 = 0, nfrm0 = 0, novf0 = 0;
    int npar1 = 0, nfrm1 = 0, novf1 = 0;
    int nz1 = 0, run1 = 0, last_run1 = 0;
    frm_t got0[$];
    frm_t got1[$];

    uart_loop_fifo #(
        .BAUD_SET_COUNTER(B), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd0), .tx_pause(pause0),
        .txd(txd0), .rx_busy(rxb0), .tx_busy(txb0), .fifo_cnt(cnt0),
        .par_err(pe0), .frm_err(fe0), .ovf_err(oe0)
    );

    uart_loop_fifo #(
        .BAUD_SET_COUNTER(B), .DATA_BITS(7), .PARITY(2),
        .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd1), .tx_pause(pause1),
        .txd(txd1), .rx_busy(rxb1), .tx_busy(txb1), .fifo_cnt(cnt1),
        .par_err(pe1), .frm_err(fe1), .ovf_err(oe1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pe0 === 1'b1) npar0++;
        if (fe0 === 1'b1) nfrm0++;
        if (oe0 === 1'b1) novf0++;
        if (pe1 === 1'b1) npar1++;
        if (fe1 === 1'b1) nfrm1++;
        if (oe1 === 1'b1) novf1++;
        if (cnt1 !== 3'd0) nz1++;
        if (txb1 === 1'b1) run1++;
        else if (run1 != 0) begin
            last_run1 = run1;
            run1 = 0;
        end
    end

    function automatic logic txd_of(input int sel);
        return (sel == 0) ? txd0 : txd1;
    endfunction

    function automatic int gsz(input int sel);
        return (sel == 0) ? got0.size() : got1.size();
    endfunction

    function automatic frm_t get(input int sel, input int i);
        frm_t f;
        f = '{data: 8'h00, par: 1'b0, stop_ok: 1'b0, t0: -1};
        if (sel == 0 && i < got0.size()) f = got0[i];
        if (sel == 1 && i < got1.size()) f = got1[i];
        return f;
    endfunction

    // even parity over the 7 payload bits of the 7E2 link
    function automatic logic mpar(input logic [7:0] v);
        return ^(v & 8'h7F);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else rxd1 = v;
    endtask

    task automatic send(input int sel, input logic [7:0] data,
                        input bit bad_par, input bit bad_stop);
        int d;
        d = (sel == 0) ? 8 : 7;
        @(negedge clk);
        last_ts = cyc;
        drive(sel, 1'b0);
        repeat (B) @(negedge clk);
        for (int i = 0; i < d; i++) begin
            drive(sel, data[i]);
            repeat (B) @(negedge clk);
        end
        if (sel == 1) begin
            drive(sel, mpar(data) ^ bad_par);
            repeat (B) @(negedge clk);
        end
        drive(sel, !bad_stop);
        repeat (B) @(negedge clk);
        drive(sel, 1'b1);
    endtask

    task automatic wait_got(input int sel, input int n, input int limit,
                            input string tag);
        int k;
        k = 0;
        while (gsz(sel) < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(gsz(sel) >= n), 1);
    endtask

    task automatic monitor(input int sel);
        logic prev;
        frm_t f;
        int d;
        prev = 1'b1;
        d = (sel == 0) ? 8 : 7;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && txd_of(sel) === 1'b0) begin
                f.t0 = cyc;
                f.data = 8'h00;
                f.par = 1'b0;
                f.stop_ok = 1'b1;
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < d; i++) begin
                    repeat (B) @(negedge clk);
                    f.data[i] = txd_of(sel);
                end
                if (sel == 1) begin
                    repeat (B) @(negedge clk);
                    f.par = txd_of(sel);
                end
                for (int i = 0; i < ((sel == 1) ? 2 : 1); i++) begin
                    repeat (B) @(negedge clk);
                    if (txd_of(sel) !== 1'b1) f.stop_ok = 1'b0;
                end
                if (sel == 0) got0.push_back(f);
                else got1.push_back(f);
            end
            prev = txd_of(sel);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, e0, p, z, o, f0, lat;
        logic [7:0] v [6];
        logic [7:0] q [$];
        frm_t f;

        repeat (3) @(negedge clk);
        check("rst_txd0", 32'(txd0), 1);
        check("rst_txd1", 32'(txd1), 1);
        check("rst_cnt0", 32'(cnt0), 0);
        check("rst_busy0", 32'({rxb0, txb0}), 0);
        check("rst_errs0", 32'({pe0, fe0, oe0}), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 single byte with latency window
        b0 = got0.size();
        e0 = npar0 + nfrm0 + novf0;
        send(0, 8'h55, 1'b0, 1'b0);
        wait_got(0, b0 + 1, 400, "echo55_timeout");
        f = get(0, b0);
        check("echo55_data", 32'(f.data), 32'h55);
        check("echo55_stop", 32'(f.stop_ok), 1);
        lat = f.t0 - last_ts;
        check("echo55_latency", 32'(lat >= 155 && lat <= 160), 1);
        repeat (50) @(negedge clk);
        check("echo55_noerr", 32'(npar0 + nfrm0 + novf0 - e0), 0);

        // 7E2 good frame
        b1 = got1.size();
        send(1, 8'h3A, 1'b0, 1'b0);
        wait_got(1, b1 + 1, 400, "echo3a_timeout");
        f = get(1, b1);
        check("echo3a_data", 32'(f.data), 32'h3A);
        check("echo3a_par", 32'(f.par), 32'(mpar(8'h3A)));
        check("echo3a_stop", 32'(f.stop_ok), 1);
        repeat (2 * B) @(negedge clk);
        check("echo3a_busy_len", 32'(last_run1), BUSY1);

        // 7E2 parity flipped
        p = npar1;
        z = nz1;
        b1 = got1.size();
        send(1, 8'h3A, 1'b1, 1'b0);
        repeat (300) @(negedge clk);
        check("parerr_pulse", 32'(npar1 - p), 1);
        check("parerr_noecho", 32'(got1.size() - b1), 0);
        check("parerr_cnt0", 32'(nz1 - z), 0);
        check("parerr_nofrm", 32'(nfrm1), 0);

        // framing error then a following frame
        f0 = nfrm0;
        b0 = got0.size();
        send(0, 8'hA5, 1'b0, 1'b1);
        repeat (B) @(negedge clk);
        v[0] = 8'($urandom);
        send(0, v[0], 1'b0, 1'b0);
        wait_got(0, b0 + 1, 400, "frm_next_timeout");
        check("frm_pulse", 32'(nfrm0 - f0), 1);
        check("frm_next_data", 32'(get(0, b0).data), 32'(v[0]));
        repeat (300) @(negedge clk);
        check("frm_noextra", 32'(got0.size() - b0), 1);

        // overflow with TX paused
        pause0 = 1'b1;
        o = novf0;
        b0 = got0.size();
        for (int i = 0; i < 6; i++) begin
            v[i] = 8'($urandom);
            send(0, v[i], 1'b0, 1'b0);
        end
        repeat (40) @(negedge clk);
        check("ovf_cnt_full", 32'(cnt0), 4);
        check("ovf_pulses", 32'(novf0 - o), 2);
        check("ovf_paused_noecho", 32'(got0.size() - b0), 0);
        pause0 = 1'b0;
        wait_got(0, b0 + 4, 4 * LEN0 + 200, "ovf_drain_timeout");
        for (int i = 0; i < 4; i++)
            check($sformatf("ovf_order%0d", i),
                  32'(get(0, b0 + i).data), 32'(v[i]));
        for (int i = 1; i < 4; i++)
            check($sformatf("ovf_gap%0d", i),
                  32'(get(0, b0 + i).t0 - get(0, b0 + i - 1).t0), LEN0);
        repeat (400) @(negedge clk);
        check("ovf_only4", 32'(got0.size() - b0), 4);
        check("ovf_cnt_empty", 32'(cnt0), 0);

        // random 8N1 traffic with random gaps
        b0 = got0.size();
        e0 = npar0 + nfrm0 + novf0;
        q.delete();
        for (int i = 0; i < 10; i++) begin
            q.push_back(8'($urandom));
            send(0, q[i], 1'b0, 1'b0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_got(0, b0 + 10, 1000, "rand0_timeout");
        for (int i = 0; i < 10; i++)
            check($sformatf("rand0_%0d", i),
                  32'(get(0, b0 + i).data), 32'(q[i]));
        check("rand0_noerr", 32'(npar0 + nfrm0 + novf0 - e0), 0);

        // random 7E2 traffic back to back
        b1 = got1.size();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'($urandom) & 8'h7F);
            send(1, q[i], 1'b0, 1'b0);
        end
        wait_got(1, b1 + 4, 1000, "rand1_timeout");
        for (int i = 0; i < 4; i++) begin
            f = get(1, b1 + i);
            check($sformatf("rand1_data%0d", i), 32'(f.data), 32'(q[i]));
            check($sformatf("rand1_par%0d", i), 32'(f.par),
                  32'(mpar(q[i])));
            check($sformatf("rand1_stop%0d", i), 32'(f.stop_ok), 1);
        end

        // reset in the middle of TX data and RX frame
        pause0 = 1'b1;
        send(0, 8'h12, 1'b0, 1'b0);
        send(0, 8'h34, 1'b0, 1'b0);
        pause0 = 1'b0;
        fork
            send(0, 8'h56, 1'b0, 1'b0);
            begin
                repeat (5 * B) @(negedge clk);
                check("prerst_busy", 32'({rxb0, txb0}), 3);
                check("prerst_cnt", 32'(cnt0), 1);
                rst = 1'b1;
                #1;
                check("rst_mid_txd", 32'(txd0), 1);
                check("rst_mid_cnt", 32'(cnt0), 0);
                check("rst_mid_busy", 32'({rxb0, txb0}), 0);
            end
        join
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        b0 = got0.size();
        v[0] = 8'($urandom);
        send(0, v[0], 1'b0, 1'b0);
        wait_got(0, b0 + 1, 400, "postrst_timeout");
        check("postrst_data", 32'(get(0, b0).data), 32'(v[0]));
        repeat (300) @(negedge clk);
        check("postrst_only1", 32'(got0.size() - b0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
